sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_ctrl_pkg.sv | 13 +
 rtl/sipo_frame_ctrl_if.sv | 25 ++
 rtl/sipo_shift_en.sv | 26 ++
 rtl/sipo_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    // One-hot state codes; any other code is treated as unreachable.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        STALL = 3'b100
    } state_t;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial input and parallel output handshake bundle of the frame controller.
interface sipo_frame_ctrl_if
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             serial_in;
    logic             bit_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output serial_in, bit_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  serial_in, bit_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/sipo_shift_en.sv
// Right-shift register: new bit enters the MSB, the first bit ends in bit 0.
module sipo_shift_en
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Clear wins over shift so an abort always empties the register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: assembles serial bits into WIDTH-bit words, cfg_words per frame.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       cfg_words,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    output logic             start_err,
    sipo_frame_ctrl_if.slave bus
);

    localparam int unsigned       CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [7:0]         words_left, words_left_nx;
    logic [WIDTH-1:0]   out_data_q, out_data_nx;
    logic               out_valid_q, out_valid_nx;
    logic               in_ready_q, in_ready_nx;
    logic               frame_done_nx, start_err_nx;
    logic               shift_en, shift_clr, load;
    logic [WIDTH-1:0]   shift_q;

    sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (shift_en),
        .clr     (shift_clr),
        .din     (bus.serial_in),
        .q       (shift_q)
    );

    // Next-state, counter and output-register logic; abort overrides everything.
    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        words_left_nx = words_left;
        out_data_nx   = out_data_q;
        out_valid_nx  = out_valid_q && !bus.out_ready;
        frame_done_nx = 1'b0;
        start_err_nx  = 1'b0;
        shift_en      = 1'b0;
        shift_clr     = 1'b0;
        load          = 1'b0;

        if (abort) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            shift_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_words != 8'd0) begin
                            words_left_nx = cfg_words;
                            bit_cnt_nx    = '0;
                            state_nx      = SHIFT;
                        end else begin
                            start_err_nx = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.bit_valid && in_ready_q) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST) begin
                            bit_cnt_nx = '0;
                            if (!out_valid_q || bus.out_ready) begin
                                load        = 1'b1;
                                out_data_nx = {bus.serial_in, shift_q[WIDTH-1:1]};
                            end else begin
                                state_nx = STALL;
                            end
                        end else begin
                            bit_cnt_nx = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (bus.out_ready) begin
                        load        = 1'b1;
                        out_data_nx = shift_q;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase

            if (load) begin
                out_valid_nx  = 1'b1;
                words_left_nx = words_left - 8'd1;
                if (words_left == 8'd1) begin
                    frame_done_nx = 1'b1;
                    state_nx      = IDLE;
                end else begin
                    state_nx = SHIFT;
                end
            end
        end

        in_ready_nx = (state_nx == SHIFT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            words_left  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_done  <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            words_left  <= words_left_nx;
            out_data_q  <= out_data_nx;
            out_valid_q <= out_valid_nx;
            in_ready_q  <= in_ready_nx;
            frame_done  <= frame_done_nx;
            start_err   <= start_err_nx;
        end
    end

    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with WIDTH=4.
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] cfg_words;
    logic       abort;
    logic       busy;
    logic       frame_done;
    logic       start_err;
    int         n_checks;
    int         n_pass;

    sipo_frame_ctrl_if #(.WIDTH(4)) bus ();

    sipo_frame_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cfg_words  (cfg_words),
        .abort      (abort),
        .busy       (busy),
        .frame_done (frame_done),
        .start_err  (start_err),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        bus.bit_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0h want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0h want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0h want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 4'h0) $display("FAIL rst_out_data: got %0h want 0", bus.out_data); else n_pass++;
        n_checks++; if ({frame_done, start_err} !== 2'b00) $display("FAIL rst_pulses: got %0h want 0", {frame_done, start_err}); else n_pass++;
        reset_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_after: got %0h want 0", busy); else n_pass++;
    endtask

    task automatic test_single_word;
        bus.out_ready = 1'b1;
        cfg_words = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %0h want 1", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready: got %0h want 1", bus.in_ready); else n_pass++;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid: got %0h want 0", bus.out_valid); else n_pass++;
        send_bit(1'b1);
        bus.bit_valid = 1'b0;
        n_checks++; if (bus.out_data !== 4'b1101) $display("FAIL single_data: got %0h want d", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %0h want 1", bus.out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL single_frame_done: got %0h want 1", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %0h want 0", busy); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_valid_clear: got %0h want 0", bus.out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL single_fd_pulse: got %0h want 0", frame_done); else n_pass++;
    endtask

    task automatic test_multi_word;
        logic [3:0] w [3];
        int         gaps;
        int         spurious;
        logic       fd_exp;
        w[0] = 4'hA;
        w[1] = 4'h3;
        w[2] = 4'h6;
        gaps = 0;
        spurious = 0;
        bus.out_ready = 1'b1;
        cfg_words = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.in_ready !== 1'b1) gaps++;
            send_bit(w[2'(c / 4)][2'(c % 4)]);
            if ((c % 4) == 3) begin
                fd_exp = (c == 11);
                n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL multi_valid%0d: got %0h want 1", c / 4, bus.out_valid); else n_pass++;
                n_checks++; if (bus.out_data !== w[2'(c / 4)]) $display("FAIL multi_data%0d: got %0h want %0h", c / 4, bus.out_data, w[2'(c / 4)]); else n_pass++;
                n_checks++; if (frame_done !== fd_exp) $display("FAIL multi_fd%0d: got %0h want %0h", c / 4, frame_done, fd_exp); else n_pass++;
            end else if (bus.out_valid !== 1'b0) begin
                spurious++;
            end
        end
        bus.bit_valid = 1'b0;
        n_checks++; if (gaps !== 0) $display("FAIL multi_in_ready_gaps: got %0d want 0", gaps); else n_pass++;
        n_checks++; if (spurious !== 0) $display("FAIL multi_spurious_valid: got %0d want 0", spurious); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL multi_idle: got %0h want 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_stall;
        logic [3:0] w1;
        logic [3:0] w2;
        w1 = 4'h5;
        w2 = 4'hC;
        bus.out_ready = 1'b1;
        cfg_words = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(w1[i]);
        n_checks++; if (bus.out_data !== w1) $display("FAIL stall_word1: got %0h want 5", bus.out_data); else n_pass++;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(w2[i]);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %0h want 0", bus.in_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy: got %0h want 1", busy); else n_pass++;
        send_bit(1'b1);
        bus.bit_valid = 1'b0;
        n_checks++; if (bus.out_data !== w1) $display("FAIL stall_hold_data: got %0h want 5", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_hold_valid: got %0h want 1", bus.out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL stall_early_fd: got %0h want 0", frame_done); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_data !== w2) $display("FAIL stall_word2: got %0h want c", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_word2_valid: got %0h want 1", bus.out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL stall_fd: got %0h want 1", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL stall_idle: got %0h want 0", busy); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall_valid_clear: got %0h want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_abort;
        logic [3:0] w;
        w = 4'h9;
        bus.out_ready = 1'b0;
        cfg_words = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bit(w[0]);
        cfg_words = 8'd0;
        start = 1'b1;
        send_bit(w[1]);
        start = 1'b0;
        n_checks++; if (start_err !== 1'b0) $display("FAIL abort_start_in_shift: got %0h want 0", start_err); else n_pass++;
        send_bit(w[2]);
        send_bit(w[3]);
        n_checks++; if (bus.out_data !== w) $display("FAIL abort_prev_word: got %0h want 9", bus.out_data); else n_pass++;
        send_bit(1'b1);
        send_bit(1'b1);
        abort = 1'b1;
        send_bit(1'b1);
        abort = 1'b0;
        bus.bit_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got %0h want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready: got %0h want 0", bus.in_ready); else n_pass++;
        n_checks++; if (dut.shift_q !== 4'h0) $display("FAIL abort_shift_clear: got %0h want 0", dut.shift_q); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL abort_keep_valid: got %0h want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== w) $display("FAIL abort_keep_data: got %0h want 9", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_valid_drain: got %0h want 0", bus.out_valid); else n_pass++;
        cfg_words = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        bus.bit_valid = 1'b0;
        n_checks++; if (bus.out_data !== 4'h6) $display("FAIL abort_clean_word: got %0h want 6", bus.out_data); else n_pass++;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL abort_clean_fd: got %0h want 1", frame_done); else n_pass++;
        tick();
    endtask

    task automatic test_start_err;
        cfg_words = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (start_err !== 1'b1) $display("FAIL serr_pulse: got %0h want 1", start_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL serr_busy: got %0h want 0", busy); else n_pass++;
        tick();
        n_checks++; if (start_err !== 1'b0) $display("FAIL serr_one_cycle: got %0h want 0", start_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL serr_stay_idle: got %0h want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        cfg_words = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0h want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %0h want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %0h want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 4'h0) $display("FAIL rmid_out_data: got %0h want 0", bus.out_data); else n_pass++;
        n_checks++; if ({frame_done, start_err} !== 2'b00) $display("FAIL rmid_pulses: got %0h want 0", {frame_done, start_err}); else n_pass++;
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_no_resume: got %0h want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_no_resume_rdy: got %0h want 0", bus.in_ready); else n_pass++;
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        start         = 1'b0;
        cfg_words     = 8'd0;
        abort         = 1'b0;
        bus.serial_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_word();
        test_multi_word();
        test_stall();
        test_abort();
        test_start_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
